// File: rtl/mac_accumulator.sv
// Group accumulator behind the PE multiplier: sums in_last-delimited
// product groups and hands each result downstream over valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-high (1 = reset)
//   in_valid   in_prod / in_last valid
//   in_ready   stage can accept a beat
//   in_prod    signed/unsigned product, WIDTH_MUL bits
//   in_last    final beat of the current group
//   out_valid  group result valid
//   out_ready  downstream accepts result
//   out_acc    group sum, WIDTH_ACC bits
//   out_ovf    saturation/wrap occurred in this group
//   out_count  beats in this group (saturating)
module mac_accumulator #(
    parameter int WIDTH_MUL = 16,
    parameter int WIDTH_ACC = 32,
    parameter bit SIGNED    = 1'b1,
    parameter bit SATURATE  = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_MUL-1:0] in_prod,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_ACC-1:0] out_acc,
    output logic                 out_ovf,
    output logic [CNT_W-1:0]     out_count
);

    localparam int EXT_W = WIDTH_ACC + 1 - WIDTH_MUL;

    localparam logic [WIDTH_ACC-1:0] S_MAX =
        {1'b0, {(WIDTH_ACC-1){1'b1}}};
    localparam logic [WIDTH_ACC-1:0] S_MIN =
        {1'b1, {(WIDTH_ACC-1){1'b0}}};
    localparam logic [WIDTH_ACC-1:0] U_MAX = '1;
    localparam logic [CNT_W-1:0]     CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_ACC-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic                 start;
    logic [WIDTH_ACC:0]   prod_x;
    logic [WIDTH_ACC:0]   base_x;
    logic [WIDTH_ACC:0]   sum_x;
    logic                 sum_ovf;
    logic [WIDTH_ACC-1:0] sum_fix;

    assign in_ready = (state_q != HOLD) || out_ready;
    assign accept   = in_valid && in_ready;
    // Any beat outside ACCUM opens a fresh group, including one
    // taken while the held result drains.
    assign start    = (state_q != ACCUM);

    always_comb begin
        prod_x = {{EXT_W{SIGNED & in_prod[WIDTH_MUL-1]}}, in_prod};
        base_x = '0;
        if (!start) begin
            base_x = {SIGNED & acc_q[WIDTH_ACC-1], acc_q};
        end
        sum_x = base_x + prod_x;
        // Signed: the extra bit disagrees with the top result bit.
        // Unsigned: a carry out of the result width.
        if (SIGNED) begin
            sum_ovf = sum_x[WIDTH_ACC] ^ sum_x[WIDTH_ACC-1];
        end else begin
            sum_ovf = sum_x[WIDTH_ACC];
        end
        sum_fix = sum_x[WIDTH_ACC-1:0];
        if (sum_ovf && SATURATE) begin
            if (SIGNED) begin
                sum_fix = sum_x[WIDTH_ACC] ? S_MIN : S_MAX;
            end else begin
                sum_fix = U_MAX;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, ACCUM, HOLD: begin
                if (accept) begin
                    acc_d = sum_fix;
                    if (start) begin
                        cnt_d = CNT_W'(1);
                        ovf_d = sum_ovf;
                    end else begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        ovf_d = ovf_q | sum_ovf;
                    end
                    state_d = in_last ? HOLD : ACCUM;
                end else if (state_q == HOLD && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = cnt_q;

endmodule
